// File: rtl/contador_luz.sv
// ---------------------------------------------------------------------------
// contador_luz
//
// Wrapping event/blink counter. Counts in the range 0..MAX and flips `luz`
// every time the count wraps. Each wrap also raises `tc` for one cycle and
// bumps the saturating lap counter `voltas`. Replaces the old fixed 6-bit
// free-running fio/luz counter.
//
// Configuration macro:
//   CONTADOR_DESCE_EN  defined   -> up/down counter, `sobe` selects direction
//                      undefined -> up-only counter, `sobe` is ignored and no
//                                   down-count logic is built
//
// Parameters:
//   WIDTH     width of cont / carga_val (1..32)
//   MAX       terminal count, 1..2**WIDTH-1
//   VOLTAS_W  width of the lap counter
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   en         in   count enable
//   sobe       in   direction: 1 = up, 0 = down (only with CONTADOR_DESCE_EN)
//   carga      in   synchronous load strobe (wins over en)
//   carga_val  in   load value, clamped to MAX
//   cont       out  current count (registered)
//   luz        out  toggles on every wrap (registered)
//   tc         out  one-cycle wrap pulse (registered)
//   voltas     out  completed laps, saturating (registered)
// ---------------------------------------------------------------------------
module contador_luz #(
  parameter int              WIDTH    = 6,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              VOLTAS_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sobe,
  input  logic                carga,
  input  logic [WIDTH-1:0]    carga_val,
  output logic [WIDTH-1:0]    cont,
  output logic                luz,
  output logic                tc,
  output logic [VOLTAS_W-1:0] voltas
);

  // Terminal value and helper constants, all held in WIDTH bits so every
  // comparison happens against MAX rather than relying on natural overflow.
  localparam logic [WIDTH-1:0]    max_c    = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0]    zero_c   = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0]    one_c    = WIDTH'(1'b1);
  localparam logic [VOLTAS_W-1:0] vzero_c  = VOLTAS_W'(1'b0);
  localparam logic [VOLTAS_W-1:0] vone_c   = VOLTAS_W'(1'b1);
  localparam logic [VOLTAS_W-1:0] vmax_c   = {VOLTAS_W{1'b1}};

  // Clamp a load value into the legal count range.
  function automatic logic [WIDTH-1:0] clamp_carga(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > max_c) begin
      r = max_c;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Saturating increment of the lap counter.
  function automatic logic [VOLTAS_W-1:0] sat_inc(input logic [VOLTAS_W-1:0] v);
    logic [VOLTAS_W-1:0] r;
    if (v == vmax_c) begin
      r = v;
    end else begin
      r = v + vone_c;
    end
    return r;
  endfunction

  // State registers
  logic [WIDTH-1:0]    cont_r;
  logic                luz_r;
  logic                tc_r;
  logic [VOLTAS_W-1:0] voltas_r;

  // Next-state values
  logic [WIDTH-1:0]    cont_s;
  logic                luz_s;
  logic                tc_s;
  logic [VOLTAS_W-1:0] voltas_s;

  // Step results for each direction and the wrap flag of the chosen step
  logic [WIDTH-1:0]    cont_sobe_s;
  logic                wrap_sobe_s;
  logic                desce_s;
  logic                wrap_s;

  // Upward step: MAX wraps to 0.
  always_comb begin
    cont_sobe_s = cont_r;
    wrap_sobe_s = 1'b0;
    if (cont_r == max_c) begin
      cont_sobe_s = zero_c;
      wrap_sobe_s = 1'b1;
    end else begin
      cont_sobe_s = cont_r + one_c;
      wrap_sobe_s = 1'b0;
    end
  end

`ifdef CONTADOR_DESCE_EN
  logic [WIDTH-1:0] cont_desce_s;
  logic             wrap_desce_s;

  // Downward step: 0 wraps to MAX.
  always_comb begin
    cont_desce_s = cont_r;
    wrap_desce_s = 1'b0;
    if (cont_r == zero_c) begin
      cont_desce_s = max_c;
      wrap_desce_s = 1'b1;
    end else begin
      cont_desce_s = cont_r - one_c;
      wrap_desce_s = 1'b0;
    end
  end

  // Direction is taken straight from the pin at the edge it is sampled.
  assign desce_s = ~sobe;
`else
  // Up-only build: the direction pin is deliberately left unused.
  logic sobe_unused_s;
  assign sobe_unused_s = sobe;
  assign desce_s       = 1'b0;
`endif

  // Count next state: load beats enable, enable beats hold.
  always_comb begin
    cont_s = cont_r;
    wrap_s = 1'b0;
    if (carga) begin
      // A load suppresses any wrap that would otherwise have happened.
      cont_s = clamp_carga(carga_val);
      wrap_s = 1'b0;
    end else if (en) begin
`ifdef CONTADOR_DESCE_EN
      if (desce_s) begin
        cont_s = cont_desce_s;
        wrap_s = wrap_desce_s;
      end else begin
        cont_s = cont_sobe_s;
        wrap_s = wrap_sobe_s;
      end
`else
      if (desce_s) begin
        cont_s = cont_r;
        wrap_s = 1'b0;
      end else begin
        cont_s = cont_sobe_s;
        wrap_s = wrap_sobe_s;
      end
`endif
    end else begin
      cont_s = cont_r;
      wrap_s = 1'b0;
    end
  end

  // Wrap side effects: toggle, pulse and lap count all move on the same edge.
  always_comb begin
    luz_s    = luz_r;
    tc_s     = 1'b0;
    voltas_s = voltas_r;
    if (wrap_s) begin
      luz_s    = ~luz_r;
      tc_s     = 1'b1;
      voltas_s = sat_inc(voltas_r);
    end else begin
      luz_s    = luz_r;
      tc_s     = 1'b0;
      voltas_s = voltas_r;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cont_r   <= zero_c;
      luz_r    <= 1'b0;
      tc_r     <= 1'b0;
      voltas_r <= vzero_c;
    end else begin
      cont_r   <= cont_s;
      luz_r    <= luz_s;
      tc_r     <= tc_s;
      voltas_r <= voltas_s;
    end
  end

  assign cont   = cont_r;
  assign luz    = luz_r;
  assign tc     = tc_r;
  assign voltas = voltas_r;

endmodule
